// File: rtl/crc_engine_param.sv
// ============================================================================
//  Module      : crc_engine_param
//  Description : Streaming MSB-first CRC engine, CRC_W-bit result, BPC message
//                bits folded per clock, runtime-loadable polynomial.
//                Optional macro CRC_FINAL_XOR_EN adds XOR_OUT on the result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_engine_param #(
    parameter int               CRC_W        = 5,
    parameter int               DATA_W       = 32,
    parameter int               BPC          = 2,
    parameter logic [CRC_W-1:0] INIT         = '0,
    parameter logic [CRC_W:0]   DEFAULT_POLY = 6'b100101
`ifdef CRC_FINAL_XOR_EN
    ,
    parameter logic [CRC_W-1:0] XOR_OUT      = '1
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_last,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [CRC_W:0]    poly,
    input  logic              poly_in_valid,
    output logic              poly_in_ready,
    output logic [CRC_W-1:0]  out,
    output logic              outvalid,
    input  logic              outready
);

    localparam int         c_BEATS = DATA_W / BPC;
    localparam int         c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    if (((DATA_W % BPC) != 0) || (CRC_W < 2)) begin : g_param_check
        $error("crc_engine_param: DATA_W must be a multiple of BPC and CRC_W must be >= 2");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CRC_W-1:0]   r_crc;
    logic [CRC_W-1:0]   r_poly;
    logic [CRC_W-1:0]   r_out;
    logic [DATA_W-1:0]  r_word;
    logic               r_last;
    logic               r_msg_active;
    logic [c_CNT_W-1:0] r_beat;
    logic               r_data_in_ready;
    logic               r_poly_in_ready;
    logic               r_outvalid;

    logic               w_data_hs;
    logic               w_poly_hs;
    logic               w_out_hs;
    logic               w_last_beat;
    logic [BPC-1:0]     w_bits;
    logic [CRC_W-1:0]   w_crc_fold;
    logic [CRC_W-1:0]   w_crc_final;
    logic               w_msg_active_nxt;
    logic               w_data_in_ready_nxt;
    logic               w_poly_in_ready_nxt;
    logic               w_outvalid_nxt;
    logic               w_unused_poly_msb;

    // The x^CRC_W term is always implied, so the top polynomial bit is never stored.
    assign w_unused_poly_msb = poly[CRC_W];

    function automatic logic [CRC_W-1:0] f_fold(
        input logic [CRC_W-1:0] crc,
        input logic [BPC-1:0]   bits,
        input logic [CRC_W-1:0] p
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc;
        for (int i = BPC - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ bits[i];
            c  = (c << 1) ^ (fb ? p : '0);
        end
        return c;
    endfunction

    assign w_data_hs   = data_in_valid && r_data_in_ready && (r_state == c_IDLE);
    assign w_poly_hs   = poly_in_valid && r_poly_in_ready;
    assign w_out_hs    = r_outvalid && outready;
    assign w_last_beat = (r_beat == c_CNT_W'(c_BEATS - 1));
    assign w_bits      = r_word[DATA_W-1 -: BPC];
    assign w_crc_fold  = f_fold(r_crc, w_bits, r_poly);
`ifdef CRC_FINAL_XOR_EN
    assign w_crc_final = w_crc_fold ^ XOR_OUT;
`else
    assign w_crc_final = w_crc_fold;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_data_hs)   w_state_nxt = c_SHIFT;
            c_SHIFT: if (w_last_beat) w_state_nxt = r_last ? c_DONE : c_IDLE;
            c_DONE:  if (w_out_hs)    w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they read 0 in reset.
    always_comb begin
        w_msg_active_nxt = r_msg_active;
        if (w_data_hs) w_msg_active_nxt = 1'b1;
        if (w_out_hs)  w_msg_active_nxt = 1'b0;
        w_data_in_ready_nxt = (w_state_nxt == c_IDLE);
        w_poly_in_ready_nxt = (w_state_nxt == c_IDLE) && !w_msg_active_nxt;
        w_outvalid_nxt      = (w_state_nxt == c_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc           <= INIT;
            r_poly          <= DEFAULT_POLY[CRC_W-1:0];
            r_out           <= '0;
            r_word          <= '0;
            r_last          <= 1'b0;
            r_msg_active    <= 1'b0;
            r_beat          <= '0;
            r_data_in_ready <= 1'b0;
            r_poly_in_ready <= 1'b0;
            r_outvalid      <= 1'b0;
        end else begin
            r_msg_active    <= w_msg_active_nxt;
            r_data_in_ready <= w_data_in_ready_nxt;
            r_poly_in_ready <= w_poly_in_ready_nxt;
            r_outvalid      <= w_outvalid_nxt;
            if (w_poly_hs) begin
                r_poly <= poly[CRC_W-1:0];
            end
            case (r_state)
                c_IDLE: begin
                    if (w_data_hs) begin
                        r_word <= data_in;
                        r_last <= data_in_last;
                        r_beat <= '0;
                    end
                end
                c_SHIFT: begin
                    r_crc  <= w_crc_fold;
                    r_word <= r_word << BPC;
                    r_beat <= r_beat + 1'b1;
                    if (w_last_beat && r_last) begin
                        r_out <= w_crc_final;
                    end
                end
                c_DONE: begin
                    if (w_out_hs) begin
                        r_crc <= INIT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_in_ready = r_data_in_ready;
    assign poly_in_ready = r_poly_in_ready;
    assign outvalid      = r_outvalid;
    assign out           = r_out;

endmodule

`default_nettype wire

// File: tb/tb_crc_engine_param.sv
// ============================================================================
//  Module      : tb_crc_engine_param
//  Description : Self-checking bench for crc_engine_param, long-division model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_engine_param;

    localparam int               CRC_W    = 5;
    localparam int               DATA_W   = 32;
    localparam int               BPC      = 2;
    localparam int               BEATS    = DATA_W / BPC;
    localparam logic [CRC_W-1:0] INIT     = '0;
    localparam logic [CRC_W:0]   DEF_POLY = 6'b100101;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              data_in_last;
    logic              data_in_valid;
    logic              data_in_ready;
    logic [CRC_W:0]    poly;
    logic              poly_in_valid;
    logic              poly_in_ready;
    logic [CRC_W-1:0]  out;
    logic              outvalid;
    logic              outready;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CRC_W:0]   cur_poly;
    logic [CRC_W-1:0] last_out;

    crc_engine_param #(
        .CRC_W       (CRC_W),
        .DATA_W      (DATA_W),
        .BPC         (BPC),
        .INIT        (INIT),
        .DEFAULT_POLY(DEF_POLY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_in_last (data_in_last),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .poly         (poly),
        .poly_in_valid(poly_in_valid),
        .poly_in_ready(poly_in_ready),
        .out          (out),
        .outvalid     (outvalid),
        .outready     (outready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Remainder of (message * x^CRC_W) divided by the generator, by long division.
    function automatic logic [CRC_W-1:0] model(input logic [DATA_W-1:0] w[$], input logic [CRC_W:0] p);
        logic             b[$];
        logic [CRC_W-1:0] init_v;
        logic [CRC_W-1:0] r;
        init_v = INIT;
        foreach (w[i]) begin
            for (int j = DATA_W - 1; j >= 0; j--) b.push_back(w[i][j]);
        end
        for (int j = 0; j < CRC_W; j++) b.push_back(1'b0);
        for (int j = 0; j < CRC_W; j++) b[j] = b[j] ^ init_v[CRC_W-1-j];
        for (int i = 0; i < b.size() - CRC_W; i++) begin
            if (b[i]) begin
                for (int j = 0; j <= CRC_W; j++) b[i+j] = b[i+j] ^ p[CRC_W-j];
            end
        end
        for (int j = 0; j < CRC_W; j++) r[CRC_W-1-j] = b[b.size()-CRC_W+j];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_data_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (data_in_ready) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic run_msg(input string tag, input logic [DATA_W-1:0] w[$], input bit ld_poly,
                           input logic [CRC_W:0] p, input int hold);
        logic [CRC_W-1:0] exp;
        int               lat;
        bit               ok, is_last, rdy_seen, ov_early, stable;
        if (ld_poly) cur_poly = {1'b1, p[CRC_W-1:0]};
        exp = model(w, cur_poly);
        foreach (w[i]) begin
            wait_data_ready(ok);
            check({tag, ":wait_ready"}, 64'(ok), 64'd1);
            if (i == 0 && ld_poly) begin
                check({tag, ":poly_ready_idle"}, 64'(poly_in_ready), 64'd1);
                poly          = p;
                poly_in_valid = 1'b1;
            end
            if (i > 0) begin
                check({tag, ":poly_ready_mid"}, 64'(poly_in_ready), 64'd0);
                poly          = CRC_W'($urandom) ^ 6'b111111;
                poly_in_valid = 1'b1;
            end
            is_last       = (i == w.size() - 1);
            data_in       = w[i];
            data_in_last  = is_last;
            data_in_valid = 1'b1;
            tick();
            data_in_valid = 1'b0;
            data_in_last  = 1'b0;
            poly_in_valid = 1'b0;
            lat      = -1;
            rdy_seen = 1'b0;
            ov_early = 1'b0;
            for (int k = 1; k <= BEATS + 8; k++) begin
                tick();
                if (is_last) begin
                    if (outvalid) begin
                        lat = k;
                        break;
                    end
                    if (data_in_ready) rdy_seen = 1'b1;
                end else begin
                    if (outvalid) ov_early = 1'b1;
                    if (data_in_ready) begin
                        lat = k;
                        break;
                    end
                end
            end
            check({tag, ":latency"}, 64'(lat), 64'(BEATS));
            if (is_last) check({tag, ":ready_in_shift"}, 64'(rdy_seen), 64'd0);
            else         check({tag, ":early_outvalid"}, 64'(ov_early), 64'd0);
        end
        check({tag, ":crc"}, 64'(out), 64'(exp));
        check({tag, ":ready_in_done"}, 64'(data_in_ready), 64'd0);
        last_out = out;
        if (hold > 0) begin
            stable = 1'b1;
            for (int k = 0; k < hold; k++) begin
                tick();
                if (!(outvalid === 1'b1 && out === exp)) stable = 1'b0;
            end
            check({tag, ":hold_stable"}, 64'(stable), 64'd1);
        end
        outready = 1'b1;
        tick();
        outready = 1'b0;
        check({tag, ":consumed"}, 64'(outvalid), 64'd0);
        check({tag, ":out_held"}, 64'(out), 64'(exp));
    endtask

    initial begin
        logic [DATA_W-1:0] q[$];
        bit                seen;
        reset         = 1'b1;
        data_in       = '0;
        data_in_last  = 1'b0;
        data_in_valid = 1'b0;
        poly          = '0;
        poly_in_valid = 1'b0;
        outready      = 1'b0;
        cur_poly      = DEF_POLY;
        last_out      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:out", 64'(out), 64'd0);
        check("rst:outvalid", 64'(outvalid), 64'd0);
        check("rst:data_ready", 64'(data_in_ready), 64'd0);
        check("rst:poly_ready", 64'(poly_in_ready), 64'd0);
        reset = 1'b0;
        tick();
        check("idle:data_ready", 64'(data_in_ready), 64'd1);
        check("idle:poly_ready", 64'(poly_in_ready), 64'd1);

        // Poly load together with the first word; known answers.
        q = '{32'h0000_0001};
        run_msg("s1", q, 1'b1, 6'b100101, 0);
        check("s1:known", 64'(last_out), 64'h05);
        q = '{32'h8000_0000};
        run_msg("s2a", q, 1'b0, '0, 0);
        check("s2a:known", 64'(last_out), 64'h05);
        q = '{32'h0000_0000};
        run_msg("s2b", q, 1'b0, '0, 0);
        check("s2b:known", 64'(last_out), 64'h00);

        // Two words, poly pulse mid-message must be ignored.
        q = '{32'h0000_0000, 32'h0000_0001};
        run_msg("s3", q, 1'b0, '0, 0);
        check("s3:known", 64'(last_out), 64'h05);

        // Back-pressure on the result, then a fresh message from INIT.
        q = '{DATA_W'($urandom)};
        run_msg("s4", q, 1'b0, '0, 10);
        q = '{32'h0000_0001};
        run_msg("s4b", q, 1'b0, '0, 0);
        check("s4b:known", 64'(last_out), 64'h05);

        // Reset in the middle of SHIFT after loading a different polynomial.
        wait_data_ready(seen);
        check("s5:wait_ready", 64'(seen), 64'd1);
        poly          = 6'b110111;
        poly_in_valid = 1'b1;
        data_in       = DATA_W'($urandom);
        data_in_last  = 1'b1;
        data_in_valid = 1'b1;
        tick();
        poly_in_valid = 1'b0;
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s5:data_ready", 64'(data_in_ready), 64'd0);
        check("s5:poly_ready", 64'(poly_in_ready), 64'd0);
        check("s5:outvalid", 64'(outvalid), 64'd0);
        check("s5:out", 64'(out), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < BEATS + 4; k++) begin
            tick();
            if (outvalid) seen = 1'b1;
        end
        check("s5:no_partial", 64'(seen), 64'd0);
        cur_poly = DEF_POLY;
        q = '{DATA_W'($urandom)};
        run_msg("s5b", q, 1'b0, '0, 0);

        // Random messages with random polynomials and back-pressure.
        for (int m = 0; m < 8; m++) begin
            q.delete();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) q.push_back(DATA_W'($urandom));
            run_msg("rnd", q, 1'($urandom_range(0, 1)), (CRC_W + 1)'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
